inst_fetch: RTL and testbench

- Instruction fetch unit for the 16-bit core; the consumer side of the PC generator.
- Reads the current PC, fetches the instruction word through a req/ack memory handshake, and hands it to execute with a valid/ready handshake.
- When execute accepts an instruction, it pulses pc_wen to the PC generator, together with the decoded branch controls (br, link, offset).
- Flushes on a PC redirect (pc_wr).

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: fetches the word at pc over a req/ack memory port,
// decodes branch controls and issues to execute with a valid/ready handshake.
module inst_fetch #(
   parameter int unsigned WAIT_LIMIT = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] pc,
   input  logic        pc_wr,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic        pc_wen,
   output logic        br,
   output logic        link,
   output logic [15:0] offset,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      DROP,
      FLUSH0,
      FLUSH1
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [15:0] addr_q;
   logic        reload;
   logic        br_q, link_q;
   logic        capture;
   logic        timeout_hit;
   logic        waiting;

   always_comb begin
      state_nxt   = state;
      mem_req     = 1'b0;
      ir_valid    = 1'b0;
      pc_wen      = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: state_nxt = pc_wr ? FLUSH0 : FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               if (pc_wr) begin
                  state_nxt = FLUSH0;
               end else begin
                  capture   = 1'b1;
                  state_nxt = ISSUE;
               end
            end else if (wait_cnt == LAST_WAIT) begin
               timeout_hit = 1'b1;
               state_nxt   = pc_wr ? FLUSH0 : IDLE;
            end else if (pc_wr) begin
               state_nxt = DROP;
            end
         end
         ISSUE: begin
            ir_valid = 1'b1;
            if (pc_wr) begin
               state_nxt = FLUSH0;
            end else if (ir_ready) begin
               pc_wen    = 1'b1;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_nxt = FLUSH0;
            end else if (wait_cnt == LAST_WAIT) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         FLUSH0: state_nxt = FLUSH1;
         FLUSH1: state_nxt = pc_wr ? FLUSH0 : FETCH;
         default: state_nxt = IDLE;
      endcase
      if ((state == FLUSH0) && pc_wr) state_nxt = FLUSH0;
   end

   assign waiting = ((state == FETCH) || (state == DROP)) && !mem_ack &&
                    !timeout_hit && (state_nxt == state);

   // After an accept the PC generator advances on the same edge, so the first
   // FETCH cycle drives the live pc and latches it for the rest of the request.
   assign mem_addr = reload ? pc : addr_q;
   assign br       = br_q & ir_valid;
   assign link     = link_q & ir_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         addr_q      <= '0;
         reload      <= 1'b0;
         ir          <= '0;
         br_q        <= 1'b0;
         link_q      <= 1'b0;
         offset      <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;

         if (waiting) wait_cnt <= wait_cnt + 8'd1;
         else         wait_cnt <= '0;

         if (timeout_hit) timeout_err <= 1'b1;

         if (capture) begin
            ir     <= mem_rdata;
            br_q   <= (mem_rdata[15:13] == 3'b111);
            link_q <= (mem_rdata[15:12] == 4'hF);
            offset <= {{5{mem_rdata[10]}}, mem_rdata[10:0]};
         end

         if (pc_wen)              reload <= 1'b1;
         else if (state == FETCH) reload <= 1'b0;

         if ((state == FETCH) && reload)
            addr_q <= pc;
         else if ((state_nxt == FETCH) && (state != FETCH) && (state != ISSUE))
            addr_q <= pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] pc;
   logic        pc_wr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic        pc_wen;
   logic        br;
   logic        link;
   logic [15:0] offset;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   inst_fetch #(.WAIT_LIMIT(8)) dut (
      .clk(clk), .resetn(resetn), .pc(pc), .pc_wr(pc_wr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .pc_wen(pc_wen), .br(br), .link(link),
      .offset(offset), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; pc = 16'h0000; pc_wr = 1'b0;
      mem_ack = 1'b0; mem_rdata = 16'h0000; ir_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, ir, ir_valid, pc_wen} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b addr=%h ir=%h v=%b wen=%b exp all zero",
                  mem_req, mem_addr, ir, ir_valid, pc_wen);
      end
      checks++;
      if ({br, link, offset, timeout_err} !== 19'd0) begin
         errors++;
         $display("FAIL reset_decode got br=%b link=%b off=%h to=%b exp all zero",
                  br, link, offset, timeout_err);
      end
      resetn = 1'b1;
   endtask

   task automatic test_basic();
      tick();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL basic_req got req=%b addr=%h exp req=1 addr=0000", mem_req, mem_addr);
      end
      tick(); mem_ack = 1'b1; mem_rdata = 16'h1234;
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'h1234 || pc_wen !== 1'b1) begin
         errors++;
         $display("FAIL basic_issue got v=%b ir=%h wen=%b exp v=1 ir=1234 wen=1",
                  ir_valid, ir, pc_wen);
      end
      checks++;
      if (br !== 1'b0 || link !== 1'b0) begin
         errors++;
         $display("FAIL basic_decode got br=%b link=%b exp 0 0", br, link);
      end
      tick(); pc = 16'h0001;
      @(negedge clk);
      checks++;
      if (pc_wen !== 1'b0 || ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
         errors++;
         $display("FAIL basic_refetch got wen=%b v=%b req=%b addr=%h exp 0 0 1 0001",
                  pc_wen, ir_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_branch_b();
      tick(); mem_ack = 1'b1; mem_rdata = 16'hE7FE;
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (pc_wen !== 1'b1 || br !== 1'b1 || link !== 1'b0 || offset !== 16'hFFFE) begin
         errors++;
         $display("FAIL branch_b got wen=%b br=%b link=%b off=%h exp 1 1 0 fffe",
                  pc_wen, br, link, offset);
      end
      tick(); pc = 16'h0010;
      @(negedge clk);
      checks++;
      if (br !== 1'b0 || mem_addr !== 16'h0010) begin
         errors++;
         $display("FAIL branch_b_masked got br=%b addr=%h exp br=0 addr=0010", br, mem_addr);
      end
   endtask

   task automatic test_branch_bl();
      tick(); mem_ack = 1'b1; mem_rdata = 16'hF005;
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (pc_wen !== 1'b1 || br !== 1'b1 || link !== 1'b1 || offset !== 16'h0005) begin
         errors++;
         $display("FAIL branch_bl got wen=%b br=%b link=%b off=%h exp 1 1 1 0005",
                  pc_wen, br, link, offset);
      end
      tick(); pc = 16'h0020;
      @(negedge clk);
      checks++;
      if (link !== 1'b0 || mem_addr !== 16'h0020) begin
         errors++;
         $display("FAIL branch_bl_masked got link=%b addr=%h exp link=0 addr=0020", link, mem_addr);
      end
   endtask

   task automatic test_stall();
      tick(); mem_ack = 1'b1; mem_rdata = 16'h4321; ir_ready = 1'b0;
      tick(); mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ir_valid !== 1'b1 || ir !== 16'h4321 || pc_wen !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b ir=%h wen=%b exp 1 4321 0",
                     i, ir_valid, ir, pc_wen);
         end
         tick();
      end
      ir_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (pc_wen !== 1'b1 || ir !== 16'h4321) begin
         errors++;
         $display("FAIL stall_accept got wen=%b ir=%h exp 1 4321", pc_wen, ir);
      end
      tick(); pc = 16'h0030;
      @(negedge clk);
      checks++;
      if (pc_wen !== 1'b0 || mem_addr !== 16'h0030) begin
         errors++;
         $display("FAIL stall_single got wen=%b addr=%h exp 0 0030", pc_wen, mem_addr);
      end
   endtask

   task automatic test_flush_fetch();
      tick(); pc_wr = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || pc_wen !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_hold got req=%b wen=%b exp 1 0", mem_req, pc_wen);
      end
      tick(); pc_wr = 1'b0; pc = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            mem_ack = 1'b1; mem_rdata = 16'hBEEF;
         end
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'h0030 || ir_valid !== 1'b0 || pc_wen !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop[%0d] got req=%b addr=%h v=%b wen=%b exp 1 0030 0 0",
                     i, mem_req, mem_addr, ir_valid, pc_wen);
         end
         tick();
      end
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || ir_valid !== 1'b0 || pc_wen !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle[%0d] got req=%b v=%b wen=%b exp 0 0 0",
                     i, mem_req, ir_valid, pc_wen);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin
         errors++;
         $display("FAIL flush_refetch got req=%b addr=%h exp 1 0100", mem_req, mem_addr);
      end
      tick(); mem_ack = 1'b1; mem_rdata = 16'h5555;
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'h5555 || pc_wen !== 1'b1) begin
         errors++;
         $display("FAIL flush_new_issue got v=%b ir=%h wen=%b exp 1 5555 1", ir_valid, ir, pc_wen);
      end
      tick(); pc = 16'h0101;
      @(negedge clk);
   endtask

   task automatic test_flush_issue();
      tick(); mem_ack = 1'b1; mem_rdata = 16'h1111;
      tick(); mem_ack = 1'b0; pc_wr = 1'b1;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || pc_wen !== 1'b0) begin
         errors++;
         $display("FAIL flush_issue_nowen got v=%b wen=%b exp 1 0", ir_valid, pc_wen);
      end
      tick(); pc_wr = 1'b0; pc = 16'h0200;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b0 || mem_req !== 1'b0 || pc_wen !== 1'b0) begin
         errors++;
         $display("FAIL flush_issue_f0 got v=%b req=%b wen=%b exp 0 0 0", ir_valid, mem_req, pc_wen);
      end
      tick();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_issue_f1 got req=%b exp 0", mem_req);
      end
      tick();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
         errors++;
         $display("FAIL flush_issue_refetch got req=%b addr=%h exp 1 0200", mem_req, mem_addr);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait[%0d] got req=%b err=%b exp 1 0", i, mem_req, timeout_err);
         end
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fire got req=%b err=%b exp 0 1", mem_req, timeout_err);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_refetch got req=%b addr=%h err=%b exp 1 0200 1",
                  mem_req, mem_addr, timeout_err);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || timeout_err !== 1'b0 || mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset got req=%b err=%b addr=%h exp 0 0 0000",
                  mem_req, timeout_err, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      pc = 16'h0300;
      @(negedge clk);
      resetn = 1'b1;
      tick(); mem_ack = 1'b1; mem_rdata = 16'h0A0A;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
         errors++;
         $display("FAIL b2b_req got req=%b addr=%h exp 1 0300", mem_req, mem_addr);
      end
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'h0A0A || pc_wen !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got v=%b ir=%h wen=%b exp 1 0a0a 1", ir_valid, ir, pc_wen);
      end
      tick(); pc = 16'h0301; mem_ack = 1'b1; mem_rdata = 16'h0B0B;
      @(negedge clk);
      checks++;
      if (mem_addr !== 16'h0301 || pc_wen !== 1'b0 || ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap got addr=%h wen=%b v=%b exp 0301 0 0", mem_addr, pc_wen, ir_valid);
      end
      tick(); mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'h0B0B || pc_wen !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got v=%b ir=%h wen=%b exp 1 0b0b 1", ir_valid, ir, pc_wen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch_b();
      test_branch_bl();
      test_stall();
      test_flush_fetch();
      test_flush_issue();
      test_timeout();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
